// File: rtl/metronome_tempo_ctrl_pkg.sv
// Shared metronome constants, field types and the tempo step/clamp helper.
// Used by the tempo controller, its button debouncer and the port interface.
package metronome_tempo_ctrl_pkg;

  localparam int CLK_HZ_DEF      = 27000000;
  localparam int BPM_DEFAULT_DEF = 60;
  localparam int BPM_MIN_DEF     = 30;
  localparam int BPM_MAX_DEF     = 240;
  localparam int BPM_STEP_DEF    = 4;
  localparam int BEATS_DEF       = 8;
  localparam int DEB_CYCLES_DEF  = 270000;

  typedef logic [7:0] bpm_t;
  typedef logic [3:0] beat_t;

  // Widened to 9 bits so bpm+step cannot wrap before the clamp is applied.
  function automatic bpm_t bpm_next(input bpm_t bpm, input logic up, input logic dn,
                                    input bpm_t lo, input bpm_t hi, input bpm_t step);
    logic [8:0] wide;
    wide = {1'b0, bpm};
    case ({up, dn})
      2'b10:   wide = ((wide + {1'b0, step}) > {1'b0, hi}) ? {1'b0, hi} : (wide + {1'b0, step});
      2'b01:   wide = (wide < ({1'b0, lo} + {1'b0, step})) ? {1'b0, lo} : (wide - {1'b0, step});
      default: wide = {1'b0, bpm};
    endcase
    return wide[7:0];
  endfunction

endpackage

// File: rtl/metronome_tempo_ctrl_if.sv
// Button inputs and beat/tempo outputs of the metronome tempo controller.
interface metronome_tempo_ctrl_if;
  import metronome_tempo_ctrl_pkg::*;

  logic  btn_up;
  logic  btn_down;
  logic  beat_tick;
  beat_t beat_num;
  logic  accent;
  bpm_t  bpm;

  modport slave  (input  btn_up, btn_down, output beat_tick, beat_num, accent, bpm);
  modport master (output btn_up, btn_down, input  beat_tick, beat_num, accent, bpm);
endinterface

// File: rtl/metronome_tempo_ctrl_btn_debounce.sv
// Two-flop synchroniser, stable-level debounce counter and one-cycle press pulse.
module metronome_tempo_ctrl_btn_debounce #(
  parameter int DEB_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);
  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;

  // Counter only runs while the synced level disagrees with the accepted level,
  // so any bounce back to the accepted level restarts the qualification window.
  always_comb begin
    sync_d   = {sync_q[0], btn_raw};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d    = '0;
        stable_d = sync_q[1];
        press_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b00;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;
endmodule

// File: rtl/metronome_tempo_ctrl.sv
// Tempo controller: debounced up/down buttons set bpm; a phase accumulator produces
// the beat tick, the 1..BEATS beat number and the downbeat accent.
module metronome_tempo_ctrl
  import metronome_tempo_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = CLK_HZ_DEF,
  parameter int BPM_DEFAULT = BPM_DEFAULT_DEF,
  parameter int BPM_MIN     = BPM_MIN_DEF,
  parameter int BPM_MAX     = BPM_MAX_DEF,
  parameter int BPM_STEP    = BPM_STEP_DEF,
  parameter int BEATS       = BEATS_DEF,
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  metronome_tempo_ctrl_if.slave io
);
  localparam logic [31:0] THRESH   = 32'(CLK_HZ * 60);
  localparam bpm_t        BPM_RST  = bpm_t'(BPM_DEFAULT);
  localparam bpm_t        BPM_LO   = bpm_t'(BPM_MIN);
  localparam bpm_t        BPM_HI   = bpm_t'(BPM_MAX);
  localparam bpm_t        BPM_INC  = bpm_t'(BPM_STEP);
  localparam beat_t       BEAT_TOP = beat_t'(BEATS);

  logic        up_evt_s, dn_evt_s;
  logic [31:0] sum_s;
  logic [31:0] acc_q, acc_d;
  bpm_t        bpm_q, bpm_d;
  beat_t       beat_q, beat_d;
  logic        tick_q, tick_d;
  logic        accent_q, accent_d;

  metronome_tempo_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .rst_n(rst_n), .btn_raw(io.btn_up), .press(up_evt_s)
  );

  metronome_tempo_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk(clk), .rst_n(rst_n), .btn_raw(io.btn_down), .press(dn_evt_s)
  );

  // acc < THRESH and bpm < 256, so the 32-bit sum cannot overflow.
  always_comb begin
    sum_s    = acc_q + {24'd0, bpm_q};
    acc_d    = sum_s;
    tick_d   = 1'b0;
    beat_d   = beat_q;
    accent_d = accent_q;
    bpm_d    = bpm_next(bpm_q, up_evt_s, dn_evt_s, BPM_LO, BPM_HI, BPM_INC);
    if (sum_s >= THRESH) begin
      acc_d    = sum_s - THRESH;
      tick_d   = 1'b1;
      beat_d   = ((beat_q == BEAT_TOP) || (beat_q == 4'd0)) ? 4'd1 : (beat_q + 4'd1);
      accent_d = (beat_d == 4'd1);
    end else begin
      acc_d = sum_s;
    end
  end

  // Beat, tempo and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= 32'd0;
      bpm_q    <= BPM_RST;
      beat_q   <= 4'd0;
      tick_q   <= 1'b0;
      accent_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      bpm_q    <= bpm_d;
      beat_q   <= beat_d;
      tick_q   <= tick_d;
      accent_q <= accent_d;
    end
  end

  assign io.beat_tick = tick_q;
  assign io.beat_num  = beat_q;
  assign io.accent    = accent_q;
  assign io.bpm       = bpm_q;
endmodule
